// File: rtl/arbiter4_rr.sv
// Four-client round-robin arbiter with registered one-hot grant, grant hold
// while the owner keeps requesting, and forced rotation after MAX_HOLD cycles.
module arbiter4_rr #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       gnt_switch
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t           state;
   logic [1:0]       ptr;
   logic [CNT_W-1:0] hold_cnt;

   logic [3:0] others;
   logic       owner_req;
   logic       at_limit;
   logic [1:0] pick;
   logic [1:0] cand;
   logic       hit;

   // gnt is zero when idle, so masking it leaves every request eligible there
   assign others    = req & ~gnt;
   assign owner_req = |(req & gnt);
   assign at_limit  = (hold_cnt == CNT_W'(MAX_HOLD));

   // Walk the search order backwards so the nearest-to-ptr requester wins last
   always_comb begin
      pick = ptr;
      hit  = 1'b0;
      cand = ptr;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (others[cand]) begin
            pick = cand;
            hit  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= 2'd0;
         hold_cnt   <= '0;
         gnt        <= 4'b0000;
         gnt_idx    <= 2'd0;
         gnt_valid  <= 1'b0;
         gnt_switch <= 1'b0;
      end else begin
         gnt_switch <= 1'b0;
         case (state)
            IDLE: begin
               if (hit) begin
                  state      <= OWN;
                  gnt        <= 4'b0001 << pick;
                  gnt_idx    <= pick;
                  gnt_valid  <= 1'b1;
                  gnt_switch <= 1'b1;
                  hold_cnt   <= CNT_W'(1);
                  ptr        <= pick + 2'd1;
               end
            end
            OWN: begin
               // Release and preemption share the same handoff path
               if (!owner_req || (at_limit && (|others))) begin
                  if (hit) begin
                     gnt        <= 4'b0001 << pick;
                     gnt_idx    <= pick;
                     gnt_valid  <= 1'b1;
                     gnt_switch <= 1'b1;
                     hold_cnt   <= CNT_W'(1);
                     ptr        <= pick + 2'd1;
                  end else begin
                     state     <= IDLE;
                     gnt       <= 4'b0000;
                     gnt_idx   <= 2'd0;
                     gnt_valid <= 1'b0;
                     hold_cnt  <= '0;
                  end
               end else if (!at_limit) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
